// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, byte-lane data memory (DEPTH x 32, registered
//   read) between the instruction-fetch port (word reads) and the
//   load/store port (byte/half/word reads and writes).
//   - Round-robin arbitration. Contention goes to the port that was not
//     granted last. There are no wait states.
//   - Store lane replication and byte-mask generation.
//   - Misalignment and illegal-size detection. An illegal access gets a
//     one-cycle d_err_o pulse instead of a memory access.
//   - Load data extraction with sign or zero extension, one cycle after
//     the grant.
// Ports
//   clk, rst_i                          clock, synchronous active-high reset
//   i_req_i/i_addr_i                    fetch request
//   i_gnt_o/i_rvalid_o/i_rdata_o        fetch grant and response
//   d_req_i/d_we_i/d_size_i/
//   d_unsigned_i/d_addr_i/d_wdata_i     load/store request
//   d_gnt_o/d_rvalid_o/d_rdata_o/d_err_o load/store grant and response
//   mem_*                               memory-side interface
module mem_port_arbiter #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH*4)
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [31:0]       i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [1:0]        d_size_i,
    input  logic              d_unsigned_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              d_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wr_data_o,
    output logic [3:0]        mem_bytemask_o,
    output logic              mem_write_en_o,
    output logic              mem_read_en_o,
    input  logic [31:0]       mem_rd_data_i
);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic       PORT_I  = 1'b0;
    localparam logic       PORT_D  = 1'b1;

    logic       rr_last_q,    rr_last_d;
    logic       pend_valid_q, pend_valid_d;
    logic       pend_port_q,  pend_port_d;
    logic [1:0] pend_size_q,  pend_size_d;
    logic [1:0] pend_off_q,   pend_off_d;
    logic       pend_uns_q,   pend_uns_d;
    logic       err_q,        err_d;
    logic       d_legal;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Fetch addresses are word-aligned; the low bits are dropped on purpose.
    logic unused_i_addr_lo;
    assign unused_i_addr_lo = ^i_addr_i[1:0];

    always_comb begin
        unique case (d_size_i)
            SZ_BYTE: d_legal = 1'b1;
            SZ_HALF: d_legal = ~d_addr_i[0];
            SZ_WORD: d_legal = (d_addr_i[1:0] == 2'b00);
            default: d_legal = 1'b0;
        endcase
    end

    always_comb begin
        rr_last_d      = rr_last_q;
        pend_valid_d   = 1'b0;
        pend_port_d    = pend_port_q;
        pend_size_d    = pend_size_q;
        pend_off_d     = pend_off_q;
        pend_uns_d     = pend_uns_q;
        err_d          = 1'b0;
        i_gnt_o        = 1'b0;
        d_gnt_o        = 1'b0;
        mem_addr_o     = '0;
        mem_wr_data_o  = '0;
        mem_bytemask_o = 4'b0000;
        mem_write_en_o = 1'b0;
        mem_read_en_o  = 1'b0;

        // No grants while in reset. On contention, the port not granted last wins.
        if (!rst_i) begin
            if (i_req_i && (!d_req_i || rr_last_q == PORT_D)) i_gnt_o = 1'b1;
            else if (d_req_i)                                 d_gnt_o = 1'b1;
        end

        if (i_gnt_o) begin
            rr_last_d      = PORT_I;
            mem_addr_o     = {i_addr_i[ADDR_W-1:2], 2'b00};
            mem_bytemask_o = 4'b1111;
            mem_read_en_o  = 1'b1;
            pend_valid_d   = 1'b1;
            pend_port_d    = PORT_I;
            pend_size_d    = SZ_WORD;
            pend_off_d     = 2'b00;
            pend_uns_d     = 1'b0;
        end else if (d_gnt_o) begin
            rr_last_d = PORT_D;
            if (d_legal) begin
                mem_addr_o = d_addr_i;
                unique case (d_size_i)
                    SZ_BYTE: begin
                        mem_bytemask_o = 4'b0001 << d_addr_i[1:0];
                        mem_wr_data_o  = {4{d_wdata_i[7:0]}};
                    end
                    SZ_HALF: begin
                        mem_bytemask_o = d_addr_i[1] ? 4'b1100 : 4'b0011;
                        mem_wr_data_o  = {2{d_wdata_i[15:0]}};
                    end
                    default: begin
                        mem_bytemask_o = 4'b1111;
                        mem_wr_data_o  = d_wdata_i;
                    end
                endcase
                if (d_we_i) begin
                    mem_write_en_o = 1'b1;
                end else begin
                    mem_read_en_o = 1'b1;
                    pend_valid_d  = 1'b1;
                    pend_port_d   = PORT_D;
                    pend_size_d   = d_size_i;
                    pend_off_d    = d_addr_i[1:0];
                    pend_uns_d    = d_unsigned_i;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            rr_last_q    <= PORT_I;
            pend_valid_q <= 1'b0;
            pend_port_q  <= PORT_I;
            pend_size_q  <= SZ_WORD;
            pend_off_q   <= 2'b00;
            pend_uns_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rr_last_q    <= rr_last_d;
            pend_valid_q <= pend_valid_d;
            pend_port_q  <= pend_port_d;
            pend_size_q  <= pend_size_d;
            pend_off_q   <= pend_off_d;
            pend_uns_q   <= pend_uns_d;
            err_q        <= err_d;
        end
    end

    // A read granted just before reset asserts must not report. That is why
    // the registered responses are also masked by rst_i.
    assign i_rvalid_o = pend_valid_q & (pend_port_q == PORT_I) & ~rst_i;
    assign d_rvalid_o = pend_valid_q & (pend_port_q == PORT_D) & ~rst_i;
    assign d_err_o    = err_q & ~rst_i;
    assign i_rdata_o  = mem_rd_data_i;

    assign rd_byte = mem_rd_data_i[{pend_off_q, 3'b000} +: 8];
    assign rd_half = mem_rd_data_i[{pend_off_q[1], 4'b0000} +: 16];

    always_comb begin
        unique case (pend_size_q)
            SZ_BYTE: d_rdata_o = {{24{rd_byte[7] & ~pend_uns_q}}, rd_byte};
            SZ_HALF: d_rdata_o = {{16{rd_half[15] & ~pend_uns_q}}, rd_half};
            default: d_rdata_o = mem_rd_data_i;
        endcase
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and lane-steering controller in front of the single-ported byte-lane data memory (DEPTH words × 4 byte lanes, 1-cycle registered read). It shares the memory between the instruction-fetch port (word reads only) and the load/store port (byte/half/word reads and writes). It performs round-robin arbitration, write-lane replication and byte-mask generation, misalignment detection, and read-data extraction with sign/zero extension.

## Interface
- DEPTH, 512, words in the attached memory
- ADDR_W, $clog2(DEPTH*4), byte-address width
- clk  in  1  rising-edge clock
- rst_i  in  1  synchronous, active-high reset
- i_req_i  in  1  fetch request; held with address until granted
- i_addr_i  in  ADDR_W  fetch byte address; bits [1:0] ignored
- i_gnt_o  out  1  fetch granted this cycle (combinational)
- i_rvalid_o  out  1  fetch data valid (registered)
- i_rdata_o  out  32  fetch word
- d_req_i  in  1  load/store request; held with all attributes until granted
- d_we_i  in  1  1 = store, 0 = load
- d_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_unsigned_i  in  1  zero-extend load result
- d_addr_i  in  ADDR_W  byte address
- d_wdata_i  in  32  store data, right-aligned
- d_gnt_o  out  1  load/store granted this cycle (combinational)
- d_rvalid_o  out  1  load data valid (registered)
- d_rdata_o  out  32  extended load result
- d_err_o  out  1  misaligned/illegal access, one-cycle pulse
- mem_addr_o  out  ADDR_W  to memory
- mem_wr_data_o  out  32  lane-replicated store data
- mem_bytemask_o  out  4  write lane enables
- mem_write_en_o  out  1  memory write strobe
- mem_read_en_o  out  1  memory read strobe
- mem_rd_data_i  in  32  memory read data, valid the cycle after mem_read_en_o

## Operation
- State: rr_last (port last granted, 0 = I, 1 = D); pend_valid, pend_port, pend_size, pend_off[1:0], pend_uns (read in flight).
- Arbitration runs every cycle; there are no wait states, so back-to-back grants are allowed. One request only: grant it. Both requesting: grant the port that is not rr_last. rr_last updates on every grant, including error grants.
- I grant:
  - mem_addr_o = {i_addr_i[ADDR_W-1:2], 2'b00}
  - mem_read_en_o = 1
  - captures pend_port = I and pend_size = word
- D grant, legal: legal means byte; half with addr[0] = 0; word with addr[1:0] = 0.
  - mem_addr_o = d_addr_i.
  - Store: mem_write_en_o = 1, mem_read_en_o = 0.
  - Store masks: byte 0001 << addr[1:0]; half 0011 or 1100 by addr[1]; word 1111.
  - Store data: byte replicates wdata[7:0] ×4; half replicates wdata[15:0] ×2; word passes wdata through.
  - Load: mem_read_en_o = 1 and captures pend_* from the request.
- D grant, illegal: no memory strobes. The next cycle d_err_o = 1 and d_rvalid_o = 0. A store with an error never writes.
- Read return: in the cycle after a read grant, the port selected by pend_port sees rvalid = 1.
  - Byte: mem_rd_data_i[8*off +: 8] extended.
  - Half: mem_rd_data_i[16*off[1] +: 16] extended.
  - Word: data unmodified.
  - Extension is sign unless pend_uns. The I port always gets the word.
- No grant: all mem strobes are 0, mem_bytemask_o = 0000, and mem_addr_o/mem_wr_data_o are don't-care. The memory output therefore holds its last value.
- rdata outputs are don't-care when rvalid = 0.

## Timing
- Grant cycle N (combinational from req and rr_last). Memory samples at the end of N. rvalid/err/rdata appear in N+1 (1-cycle load latency). Store completes at the end of N; there is no response beyond gnt.
- A store in N followed by a load of the same word in N+1 returns the new data.
- Reset state: rr_last = I (D wins the first contention); pend_valid = 0; i_rvalid_o = d_rvalid_o = d_err_o = 0.
- Reset is combinational into the grants: while rst_i = 1, gnt_o = 0 and all mem strobes are 0.
- A read granted in the cycle before rst_i asserts produces no rvalid. A read granted in the cycle rst_i deasserts is impossible, since no grant occurs under reset.
- Simultaneous rvalid on both ports never occurs. At most one of i_rvalid_o, d_rvalid_o, d_err_o is high per cycle.

## Test plan
- Reset, then store word 0xDEADBEEF at 0x010, then load word 0x010 -> d_gnt_o same cycle, mask 1111; load gives d_rvalid_o the next cycle with 0xDEADBEEF.
- Byte load of 0x013 signed, then unsigned -> d_rdata_o = 0xFFFFFFDE, then 0x000000DE. Half store 0x1234 at 0x012 -> mask 1100, mem_wr_data_o = 0x12341234; subsequent word read = 0x1234BEEF.
- Both ports requesting continuously for 6 cycles from reset -> grants D,I,D,I,D,I; each rvalid lands on the correct port one cycle after its grant.
- Half load at 0x011 and word store at 0x016 -> no mem strobes, d_err_o pulse the next cycle, and a later word read of 0x014 shows unchanged data.
- Assert rst_i for one cycle immediately after an I grant -> no i_rvalid_o, rr_last back to I, and the next contention grants D first.
